// File: rtl/seg7_scan_display.sv
// Buffers 32-bit debug words over valid/ready and scans them as hex onto an
// 8-digit common-anode seven-segment display, swapping words only between frames.
module seg7_scan_display #(
  parameter int SCAN_DIV = 50000,
  parameter bit LZB      = 1'b1
) (
  input  logic        CLK,
  input  logic        clr,
  input  logic [31:0] disp_data,
  input  logic [7:0]  disp_dp,
  input  logic        disp_valid,
  output logic        disp_ready,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      active_q, active_d;
  logic [7:0]       active_dp_q, active_dp_d;
  logic [31:0]      pend_q, pend_d;
  logic [7:0]       pend_dp_q, pend_dp_d;
  logic             pend_full_q, pend_full_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             frame_done_q, frame_done_d;

  logic       xfer, tick, boundary, upper_zero;
  logic [3:0] nib;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign disp_ready = !clr && !pend_full_q;
  assign xfer       = disp_valid && disp_ready;
  assign tick       = (state_q == ST_SCAN) && (div_q == DIV_LAST);
  assign boundary   = tick && (idx_q == 3'd7);
  assign nib        = active_q[{idx_q, 2'b00} +: 4];
  assign upper_zero = (active_q >> {idx_q, 2'b00}) == 32'd0;

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path
    // through the case below can leave one unassigned and infer a latch.
    state_d      = state_q;
    div_d        = div_q;
    idx_d        = idx_q;
    active_d     = active_q;
    active_dp_d  = active_dp_q;
    pend_d       = pend_q;
    pend_dp_d    = pend_dp_q;
    pend_full_d  = pend_full_q;
    frame_done_d = boundary;

    case (state_q)
      ST_IDLE: begin
        div_d = '0;
        idx_d = 3'd0;
        if (xfer) begin
          active_d    = disp_data;
          active_dp_d = disp_dp;
          state_d     = ST_SCAN;
        end
      end
      default: begin
        div_d = tick ? '0 : div_q + 1'b1;
        idx_d = tick ? idx_q + 3'd1 : idx_q;
        // Promotion reads the old pending word; a same-cycle transfer refills it.
        if (boundary && pend_full_q) begin
          active_d    = pend_q;
          active_dp_d = pend_dp_q;
          pend_full_d = 1'b0;
        end
        if (xfer) begin
          pend_d      = disp_data;
          pend_dp_d   = disp_dp;
          pend_full_d = 1'b1;
        end
      end
    endcase

    if (state_q == ST_IDLE) begin
      an_d  = 8'hFF;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
    end else begin
      an_d  = ~(8'b1 << idx_q);
      seg_d = (LZB && (idx_q != 3'd0) && upper_zero) ? 7'h7F : hex7(nib);
      dp_d  = ~active_dp_q[idx_q];
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (clr) begin
      state_q      <= ST_IDLE;
      div_q        <= '0;
      idx_q        <= 3'd0;
      // NOTE: the word buffers are reset as well; they are few flops and this
      // keeps the display path free of X after reset.
      active_q     <= '0;
      active_dp_q  <= '0;
      pend_q       <= '0;
      pend_dp_q    <= '0;
      pend_full_q  <= 1'b0;
      an_q         <= 8'hFF;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      idx_q        <= idx_d;
      active_q     <= active_d;
      active_dp_q  <= active_dp_d;
      pend_q       <= pend_d;
      pend_dp_q    <= pend_dp_d;
      pend_full_q  <= pend_full_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display: two instances (DIV=4/LZB=1, DIV=2/LZB=0) checked
// every cycle against a frame-position model, plus directed literal checks.
module tb_seg7_scan_display;

  localparam logic [6:0] HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic        CLK = 1'b0;
  logic        clr;
  logic        valid [2];
  logic [31:0] data  [2];
  logic [7:0]  dpin  [2];
  logic        ready [2];
  logic [7:0]  an    [2];
  logic [6:0]  seg   [2];
  logic        dp    [2];
  logic        fd    [2];

  always #5 CLK = ~CLK;

  seg7_scan_display #(.SCAN_DIV(4), .LZB(1'b1)) u0 (
    .CLK(CLK), .clr(clr), .disp_data(data[0]), .disp_dp(dpin[0]),
    .disp_valid(valid[0]), .disp_ready(ready[0]), .an(an[0]), .seg(seg[0]),
    .dp(dp[0]), .frame_done(fd[0]));

  seg7_scan_display #(.SCAN_DIV(2), .LZB(1'b0)) u1 (
    .CLK(CLK), .clr(clr), .disp_data(data[1]), .disp_dp(dpin[1]),
    .disp_valid(valid[1]), .disp_ready(ready[1]), .an(an[1]), .seg(seg[1]),
    .dp(dp[1]), .frame_done(fd[1]));

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit run_cmp  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position within the frame is a plain cycle count since scanning began.
  bit          m_scan  [2] = '{0, 0};
  int          m_c     [2] = '{0, 0};
  logic [31:0] m_act   [2] = '{0, 0};
  logic [7:0]  m_adp   [2] = '{0, 0};
  logic [31:0] m_pend  [2] = '{0, 0};
  logic [7:0]  m_pdp   [2] = '{0, 0};
  bit          m_pfull [2] = '{0, 0};
  logic [7:0]  e_an    [2];
  logic [6:0]  e_seg   [2];
  logic        e_dp    [2];
  logic        e_fd    [2];

  always @(posedge CLK) begin : model
    cyc <= cyc + 1;
    for (int l = 0; l < 2; l++) begin : lane
      int          div, idx, frame;
      bit          xfer, bnd, lzb;
      logic [31:0] upper;
      div   = (l == 0) ? 4 : 2;
      lzb   = (l == 0);
      frame = 8 * div;
      xfer  = valid[l] && !clr && !m_pfull[l];
      if (clr) begin
        m_scan[l] = 0; m_c[l] = 0; m_pfull[l] = 0;
        e_an[l] = 8'hFF; e_seg[l] = 7'h7F; e_dp[l] = 1'b1; e_fd[l] = 1'b0;
      end else if (!m_scan[l]) begin
        e_an[l] = 8'hFF; e_seg[l] = 7'h7F; e_dp[l] = 1'b1; e_fd[l] = 1'b0;
        if (xfer) begin
          m_scan[l] = 1; m_c[l] = 0; m_act[l] = data[l]; m_adp[l] = dpin[l];
        end
      end else begin
        idx      = (m_c[l] / div) % 8;
        upper    = m_act[l] >> (4 * idx);
        e_an[l]  = ~(8'd1 << idx);
        e_seg[l] = (lzb && idx > 0 && upper == 0) ? 7'h7F : HEX[upper & 32'hF];
        e_dp[l]  = !m_adp[l][idx];
        bnd      = (m_c[l] % frame) == frame - 1;
        e_fd[l]  = bnd;
        if (bnd && m_pfull[l]) begin
          m_act[l] = m_pend[l]; m_adp[l] = m_pdp[l]; m_pfull[l] = 0;
        end
        if (xfer) begin
          m_pend[l] = data[l]; m_pdp[l] = dpin[l]; m_pfull[l] = 1;
        end
        m_c[l] = (m_c[l] + 1) % frame;
      end
    end
  end

  always @(negedge CLK) begin : compare
    if (run_cmp) begin
      for (int l = 0; l < 2; l++) begin
        check($sformatf("model_an%0d", l), an[l], e_an[l]);
        check($sformatf("model_seg%0d", l), seg[l], e_seg[l]);
        check($sformatf("model_dp%0d", l), dp[l], e_dp[l]);
        check($sformatf("model_fd%0d", l), fd[l], e_fd[l]);
        check($sformatf("model_ready%0d", l), ready[l], !clr && !m_pfull[l]);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic wait_fd(input int l);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (fd[l] === 1'b1) seen = 1;
      else step(1);
    end
    check("fd_within_bound", seen, 1'b1);
  endtask

  initial begin : stim
    int  t1, t2;
    bit  got;
    bit  took [2];
    bit  rs   [2];
    clr = 1'b1;
    for (int l = 0; l < 2; l++) begin
      valid[l] = 1'b0; data[l] = '0; dpin[l] = '0;
    end
    step(2);
    run_cmp = 1;
    check("rst_an", an[0], 8'hFF);
    check("rst_seg", seg[0], 7'h7F);
    check("rst_dp", dp[0], 1'b1);
    check("rst_fd", fd[0], 1'b0);
    check("rst_ready", ready[0], 1'b0);

    clr = 1'b0;
    #1 check("ready_after_clr", ready[0], 1'b1);
    valid[0] = 1'b1; data[0] = 32'h1234ABCD; dpin[0] = 8'h01;
    valid[1] = 1'b1; data[1] = 32'h000000A0; dpin[1] = 8'h00;
    step(1);
    valid[0] = 1'b0; valid[1] = 1'b0;
    check("idle_blank_an", an[0], 8'hFF);
    step(1);
    check("d0_seg", seg[0], 7'b0100001);
    check("d0_an", an[0], 8'b11111110);
    check("d0_dp", dp[0], 1'b0);
    check("l1_d0_seg", seg[1], 7'b1000000);
    step(2);
    check("l1_d1_seg", seg[1], 7'b0001000);
    check("l1_d1_an", an[1], 8'hFD);
    step(2);
    check("l1_d2_nolzb", seg[1], 7'b1000000);
    check("l1_d2_an", an[1], 8'hFB);
    check("d1_seg", seg[0], 7'b1000110);

    wait_fd(0);
    t1 = cyc;
    step(1);
    wait_fd(0);
    t2 = cyc;
    check("frame_period", t2 - t1, 32);

    // Leading-zero word goes through pending, shown after next frame end.
    valid[0] = 1'b1; data[0] = 32'h000000A0; dpin[0] = 8'h00;
    step(1);
    valid[0] = 1'b0;
    wait_fd(0);
    step(1);
    check("lzb_d0", seg[0], 7'b1000000);
    step(4);
    check("lzb_d1", seg[0], 7'b0001000);
    step(4);
    check("lzb_d2_blank", seg[0], 7'h7F);
    check("lzb_d2_an", an[0], 8'hFB);
    check("lzb_d2_dp", dp[0], 1'b1);

    valid[0] = 1'b1; data[0] = 32'hFFFFFFFF; dpin[0] = 8'hFF;
    step(1);
    data[0] = 32'h0; dpin[0] = 8'h00;
    #1 check("b2b_ready_low", ready[0], 1'b0);
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (ready[0]) got = 1;
      else step(1);
    end
    check("b2b_ready_back", got, 1'b1);
    check("b2b_fd_with_ready", fd[0], 1'b1);
    step(1);
    valid[0] = 1'b0;
    check("b2b_allF", seg[0], 7'b0001110);
    check("b2b_dp", dp[0], 1'b0);
    check("b2b_pending_full", ready[0], 1'b0);

    // Transfer exactly on the boundary edge while pending is empty.
    wait_fd(0);
    step(31);
    valid[0] = 1'b1; data[0] = 32'h87654321; dpin[0] = 8'hA5;
    step(1);
    valid[0] = 1'b0;
    check("coinc_fd", fd[0], 1'b1);
    check("coinc_ready", ready[0], 1'b0);
    step(1);
    check("coinc_old_word", seg[0], 7'b1000000);
    step(20);
    clr = 1'b1;
    step(1);
    check("clr_an", an[0], 8'hFF);
    check("clr_seg", seg[0], 7'h7F);
    check("clr_ready", ready[0], 1'b0);
    clr = 1'b0;
    #1 check("clr_ready_back", ready[0], 1'b1);
    valid[0] = 1'b1; data[0] = 32'h5A5A5A5A; dpin[0] = 8'h00;
    step(1);
    valid[0] = 1'b0;
    step(1);
    check("post_clr_d0", seg[0], 7'b0001000);
    check("post_clr_an", an[0], 8'hFE);

    took = '{1, 1};
    for (int n = 0; n < 4000; n++) begin
      clr = ($urandom_range(0, 599) == 0);
      for (int l = 0; l < 2; l++) begin
        if (!(valid[l] && !took[l])) begin
          valid[l] = ($urandom_range(0, 2) == 0);
          data[l]  = $urandom >> $urandom_range(0, 31);
          dpin[l]  = 8'($urandom);
        end
      end
      #1;
      for (int l = 0; l < 2; l++) rs[l] = ready[l];
      step(1);
      for (int l = 0; l < 2; l++) took[l] = valid[l] && rs[l];
    end

    for (int l = 0; l < 2; l++) valid[l] = 1'b0;
    clr = 1'b0;
    step(2);
    run_cmp = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
- Consumer end of the debug display path. The debug selector pushes 32-bit words (register value, PC, and similar) over a valid/ready handshake; this block buffers each word and time-multiplexes it onto the board's 8-digit common-anode seven-segment display as hexadecimal.
- Holds one active word plus a one-entry pending buffer. A pending word is promoted only at a frame boundary, so the display never tears mid-frame.

Parameters:
SCAN_DIV, 50000, clock cycles each digit stays lit (≥2; benches use 4)
LZB, 1, 1 = blank leading zero digits (digit 0 is never blanked); 0 = show all digits

Ports:
CLK  input  1  system clock
clr  input  1  synchronous active-high reset
disp_data  input  32  hex word to show; nibble [3:0] appears on digit 0 (rightmost)
disp_dp  input  8  decimal-point enables per digit, 1 = lit; latched with disp_data
disp_valid  input  1  sender offers disp_data/disp_dp
disp_ready  output  1  block can accept this cycle
an  output  8  digit anodes, active-low
seg  output  7  segments {g,f,e,d,c,b,a}, active-low
dp  output  1  decimal point, active-low
frame_done  output  1  one-cycle pulse at the end of each full 8-digit scan

Behaviour:
- One clock CLK. Reset clr is synchronous and active-high. All state is registered.
- Reset values:
  - an=8'hFF, seg=7'h7F, dp=1, frame_done=0, disp_ready=0 while clr is high.
  - State=IDLE, pending empty, divider=0, digit index=0.
  - disp_ready=1 in the first cycle after clr drops.
- Handshake:
  - A transfer occurs when disp_valid && disp_ready on a rising edge.
  - disp_ready = !clr && !pending_full.
  - disp_data/disp_dp are sampled only on a transfer. Sender must hold them stable while valid && !ready.
- State IDLE:
  - Display blank; divider and index held at 0.
  - On a transfer, the word loads straight into active, and the next state is SCAN. Pending stays empty.
- State SCAN:
  - Divider counts 0..SCAN_DIV-1 and wraps. tick = (divider==SCAN_DIV-1).
  - Index advances 0→1→…→7→0 on each tick.
  - Frame boundary = tick && index==7. On it:
    - frame_done pulses for 1 cycle.
    - If pending_full: active<=pending, pending_full<=0.
  - A transfer in SCAN writes pending and sets pending_full.
  - Transfer and boundary in the same cycle, with pending empty: the new word goes to pending, not to active. It is promoted at the next boundary.
  - SCAN never returns to IDLE except by clr.
- Output mapping (registered, 1-cycle latency from index/active change):
  - an = ~(8'b1 << index).
  - nib = active[4*index+3 : 4*index].
  - seg = hex decode of nib:
    - 0:1000000, 1:1111001, 2:0100100, 3:0110000
    - 4:0011001, 5:0010010, 6:0000010, 7:1111000
    - 8:0000000, 9:0010000, A:0001000, b:0000011
    - C:1000110, d:0100001, E:0000110, F:0001110
  - dp = ~active_dp[index].
  - Leading-zero blanking: if LZB and index>0 and nibbles index..7 are all zero, then seg=7'h7F. an still strobes that digit; dp is still driven from active_dp.
- Boundary cases:
  - Back-to-back offers: the first transfer fills pending and ready drops. Ready rises the cycle after the boundary that drains pending.
  - clr mid-frame discards active and pending, blanks the display the cycle after clr is sampled, and returns to IDLE.
  - Divider wrap and index wrap are exact modulo; there are no skipped or doubled digits.

Test Plan:
- Reset, then offer 32'h1234ABCD, dp=8'h01, SCAN_DIV=4 → ready=1 on first post-reset cycle; transfer; digit 0 shows D (seg=0100001, an=11111110, dp=0) for 4 cycles; digits advance every 4 cycles; frame_done pulses every 32 cycles.
- LZB=1, word 32'h000000A0 → digit 0 shows 0 (1000000), digit 1 shows A, digits 2–7 seg=1111111 while an still strobes them; with LZB=0 digits 2–7 show 1000000.
- During SCAN, offer 32'hFFFFFFFF then 32'h0 on consecutive cycles → first is accepted into pending, ready=0 for the second; at the frame boundary the display switches to all F, ready returns to 1, and 32'h0 is accepted next.
- Transfer coinciding with the boundary cycle while pending is empty → the old word is displayed for one more full frame; the new word appears after the following frame_done.
- Assert clr for 1 cycle while index=5 with pending full → next cycle an=FF, seg=7F, ready=1 after clr drops; the next transfer displays immediately from IDLE.
- Divider check with SCAN_DIV=2 → each digit is lit exactly 2 cycles; index sequence 0..7 repeats with no gaps.
